// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: PC register, IF/ID register and imem request/ready handshake.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/bubble cycle counters.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h00000000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        ifflush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0] stall_cycles,
  output logic [15:0] bubble_cycles,
`endif
  output logic [31:0] ifid_pc4
);

  typedef enum logic [0:0] {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        accept_s;
  logic        bubble_load_s;
  logic [31:0] pc_plus4_s;

  assign pc_plus4_s = pc_q + 32'd4;
  assign accept_s   = (state_q == FETCH) & imem_ready & ~stall & ~ifflush & ~redirect_valid;

  // Next-state logic for the fetch FSM, PC and IF/ID register
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_pc_d  = pending_pc_q;
    ifid_valid_d  = ifid_valid_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc4_d    = ifid_pc4_q;
    bubble_load_s = 1'b0;

    if (ifflush || redirect_valid) begin
      ifid_valid_d  = 1'b0;
      ifid_instr_d  = BUBBLE_INSTR;
      bubble_load_s = 1'b1;
    end else if (stall) begin
      ifid_valid_d = ifid_valid_q;
    end else if (accept_s) begin
      ifid_valid_d = 1'b1;
      ifid_instr_d = imem_rdata;
      ifid_pc4_d   = pc_plus4_s;
    end else begin
      ifid_valid_d  = 1'b0;
      ifid_instr_d  = BUBBLE_INSTR;
      bubble_load_s = 1'b1;
    end

    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          if (imem_ready) begin
            pc_d = redirect_pc;
          end else begin
            pending_pc_d = redirect_pc;
            state_d      = DISCARD;
          end
        end else if (accept_s) begin
          pc_d = pc_plus4_s;
        end else begin
          pc_d = pc_q;
        end
      end
      DISCARD: begin
        // The outstanding response belongs to the abandoned path; only its arrival matters.
        if (redirect_valid) begin
          pending_pc_d = redirect_pc;
        end else begin
          pending_pc_d = pending_pc_q;
        end
        if (imem_ready) begin
          pc_d    = redirect_valid ? redirect_pc : pending_pc_q;
          state_d = FETCH;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      pending_pc_q <= 32'h00000000;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= BUBBLE_INSTR;
      ifid_pc4_q   <= 32'h00000000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  assign imem_req   = ~reset;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] bubble_cycles_q, bubble_cycles_d;

  // Saturating counter increments
  always_comb begin
    stall_cycles_d  = stall_cycles_q;
    bubble_cycles_d = bubble_cycles_q;
    if (stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (bubble_load_s && (bubble_cycles_q != 16'hFFFF)) begin
      bubble_cycles_d = bubble_cycles_q + 16'd1;
    end else begin
      bubble_cycles_d = bubble_cycles_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q  <= 16'd0;
      bubble_cycles_q <= 16'd0;
    end else begin
      stall_cycles_q  <= stall_cycles_d;
      bubble_cycles_q <= bubble_cycles_d;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign bubble_cycles = bubble_cycles_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed self-checking bench for if_fetch_ctrl; memory returns the bitwise complement of the address.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        ifflush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] bubble_cycles;
`endif

  int pass_cnt;
  int total_cnt;

  if_fetch_ctrl #(
    .RESET_PC    (32'h00000000),
    .BUBBLE_INSTR(32'h00000000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .ifflush       (ifflush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
`ifdef FETCH_PERF_CNT_EN
    .stall_cycles  (stall_cycles),
    .bubble_cycles (bubble_cycles),
`endif
    .ifid_pc4      (ifid_pc4)
  );

  assign imem_rdata = ~imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall          = 1'b0;
    ifflush        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h00000000;
    imem_ready     = 1'b1;
  endtask

  // expected IF/ID triple and pc after the last edge
  task automatic check_state(input string name, input logic [31:0] exp_pc, input logic exp_v,
                             input logic [31:0] exp_instr, input logic [31:0] exp_pc4);
    total_cnt++;
    if (pc !== exp_pc) $display("FAIL %s pc: got %h expected %h", name, pc, exp_pc);
    else pass_cnt++;
    total_cnt++;
    if (ifid_valid !== exp_v) $display("FAIL %s ifid_valid: got %b expected %b", name, ifid_valid, exp_v);
    else pass_cnt++;
    total_cnt++;
    if (ifid_instr !== exp_instr) $display("FAIL %s ifid_instr: got %h expected %h", name, ifid_instr, exp_instr);
    else pass_cnt++;
    total_cnt++;
    if (ifid_pc4 !== exp_pc4) $display("FAIL %s ifid_pc4: got %h expected %h", name, ifid_pc4, exp_pc4);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    check_state("reset", 32'h00000000, 1'b0, 32'h00000000, 32'h00000000);
    total_cnt++;
    if (imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h00000000)
      $display("FAIL post_reset_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_zero_wait();
    step();
    check_state("zw_0", 32'h00000004, 1'b1, 32'hFFFFFFFF, 32'h00000004);
    step();
    check_state("zw_4", 32'h00000008, 1'b1, 32'hFFFFFFFB, 32'h00000008);
    total_cnt++;
    if (imem_addr !== 32'h00000008) $display("FAIL zw_addr: got %h expected 00000008", imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    stall   = 1'b1;
    ifflush = 1'b1;
    step();
    check_state("lu_bubble", 32'h00000008, 1'b0, 32'h00000000, 32'h00000008);
    stall   = 1'b0;
    ifflush = 1'b0;
    step();
    check_state("lu_refetch", 32'h0000000C, 1'b1, 32'hFFFFFFF7, 32'h0000000C);
    step();
    check_state("lu_next", 32'h00000010, 1'b1, 32'hFFFFFFF3, 32'h00000010);
  endtask

  task automatic test_redirect_ready();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00000040;
    step();
    check_state("rdr_drop", 32'h00000040, 1'b0, 32'h00000000, 32'h00000010);
    redirect_valid = 1'b0;
    step();
    check_state("rdr_target", 32'h00000044, 1'b1, 32'hFFFFFFBF, 32'h00000044);
  endtask

  task automatic test_redirect_wait();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00000014;
    step();
    check_state("rw_setup", 32'h00000014, 1'b0, 32'h00000000, 32'h00000044);
    imem_ready  = 1'b0;
    redirect_pc = 32'h00000060;
    step();
    check_state("rw_wait1", 32'h00000014, 1'b0, 32'h00000000, 32'h00000044);
    redirect_pc = 32'h00000080;
    step();
    check_state("rw_wait2", 32'h00000014, 1'b0, 32'h00000000, 32'h00000044);
    redirect_valid = 1'b0;
    step();
    check_state("rw_wait3", 32'h00000014, 1'b0, 32'h00000000, 32'h00000044);
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h00000014)
      $display("FAIL rw_hold_addr: got req=%b addr=%h expected req=1 addr=00000014", imem_req, imem_addr);
    else pass_cnt++;
    imem_ready = 1'b1;
    step();
    check_state("rw_drop", 32'h00000080, 1'b0, 32'h00000000, 32'h00000044);
    step();
    check_state("rw_target", 32'h00000084, 1'b1, 32'hFFFFFF7F, 32'h00000084);
  endtask

  task automatic test_wrap_and_stall();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFFFFFC;
    step();
    redirect_valid = 1'b0;
    step();
    check_state("wrap", 32'h00000000, 1'b1, 32'h00000003, 32'h00000000);
    stall = 1'b1;
    step();
    check_state("stall_hold", 32'h00000000, 1'b1, 32'h00000003, 32'h00000000);
    stall = 1'b0;
    step();
    check_state("stall_release", 32'h00000004, 1'b1, 32'hFFFFFFFF, 32'h00000004);
  endtask

  task automatic test_reset_in_discard();
    imem_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00000100;
    step();
    check_state("rd_discard", 32'h00000004, 1'b0, 32'h00000000, 32'h00000004);
    redirect_valid = 1'b0;
    imem_ready     = 1'b1;
    reset          = 1'b1;
    step();
    check_state("rd_reset", 32'h00000000, 1'b0, 32'h00000000, 32'h00000000);
    reset = 1'b0;
    step();
    check_state("rd_after", 32'h00000004, 1'b1, 32'hFFFFFFFF, 32'h00000004);
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_counters();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    stall   = 1'b1;
    ifflush = 1'b1;
    repeat (3) step();
    stall          = 1'b0;
    ifflush        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00000200;
    step();
    redirect_pc = 32'h00000300;
    step();
    redirect_valid = 1'b0;
    total_cnt++;
    if (stall_cycles !== 16'd3) $display("FAIL perf_stall: got %0d expected 3", stall_cycles);
    else pass_cnt++;
    total_cnt++;
    if (bubble_cycles !== 16'd5) $display("FAIL perf_bubble: got %0d expected 5", bubble_cycles);
    else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    idle_inputs();
    test_reset();
    test_zero_wait();
    test_load_use();
    test_redirect_ready();
    test_redirect_wait();
    test_wrap_and_stall();
    test_reset_in_discard();
`ifdef FETCH_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Consumer end of the hazard-unit interface: owns the PC register and the IF/ID pipeline register.
- Applies stall (hold PC), flush (load bubble) and branch/jump redirects.
- Drives a variable-latency instruction-memory request/ready handshake.
- Sits between the hazard unit and ID stage on one side and instruction memory on the other.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
BUBBLE_INSTR, 32'h00000000, instruction word written into IF/ID on flush or fetch bubble (MIPS nop).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  from hazard unit; hold PC and do not accept fetched instruction
ifflush  input  1  from hazard unit; load bubble into IF/ID this cycle
redirect_valid  input  1  taken branch/jump/jr; next fetch from redirect_pc
redirect_pc  input  32  redirect target
imem_req  output  1  fetch request, held until imem_ready
imem_addr  output  32  fetch address, stable while imem_req=1 and imem_ready=0
imem_ready  input  1  imem_rdata valid for imem_addr this cycle
imem_rdata  input  32  fetched instruction
pc  output  32  current PC register
ifid_valid  output  1  IF/ID holds a real instruction
ifid_instr  output  32  IF/ID instruction
ifid_pc4  output  32  IF/ID PC+4 of held instruction

Behaviour:
- Reset values: pc=RESET_PC, ifid_valid=0, ifid_instr=BUBBLE_INSTR, ifid_pc4=0, state=FETCH, pending_pc=0. imem_req=0 while reset=1. A reset mid-fetch abandons the outstanding request; any imem_ready seen in the reset cycle is ignored.
- States: FETCH (request for pc outstanding), DISCARD (request outstanding but redirected; response is dropped).
- imem_req=1 in both states when not in reset. imem_addr=pc in both states; pc does not change while a request is unanswered.
- IF/ID update priority each cycle, with accept = FETCH & imem_ready & ~stall & ~ifflush & ~redirect_valid:
  - reset;
  - else ifflush or redirect_valid: bubble (valid=0, instr=BUBBLE_INSTR, pc4 unchanged);
  - else stall: hold IF/ID;
  - else accept: valid=1, instr=imem_rdata, pc4=pc+4;
  - else (no data or DISCARD): bubble.
- PC update in FETCH:
  - redirect_valid & imem_ready: pc<=redirect_pc, stay FETCH (data dropped).
  - redirect_valid & ~imem_ready: pending_pc<=redirect_pc, go DISCARD, pc held.
  - accept: pc<=pc+4 (32-bit wrap, no carry out).
  - stall with imem_ready: data dropped, pc held, same address refetched next cycle.
  - otherwise: pc held.
- PC update in DISCARD:
  - redirect_valid: pending_pc<=redirect_pc (latest wins).
  - imem_ready: data dropped; pc<=(redirect_valid ? redirect_pc : pending_pc); go FETCH.
  - stall and ifflush affect IF/ID only.
- Redirect has priority over stall for the PC.
- stall=ifflush=1 (the hazard unit's normal load-use/jump case) gives: PC held, IF/ID bubble, re-request the same address.
- Latency: an instruction reaches IF/ID on the edge where imem_ready is seen with accept=1. Zero-wait memory sustains one instruction per cycle.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined: adds outputs stall_cycles[15:0] and bubble_cycles[15:0].
  - stall_cycles increments on each non-reset cycle with stall=1.
  - bubble_cycles increments on each non-reset cycle where IF/ID is loaded with a bubble.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then zero-wait memory (imem_ready=1 always), rdata=addr-tagged words -> imem_addr 0,4,8,...; ifid_pc4 4,8,12 on consecutive cycles; ifid_valid=1 from the second cycle after reset.
- Load-use: stall=ifflush=1 for one cycle at pc=8 -> pc stays 8, IF/ID bubble (valid=0, instr=0), next cycle instruction at 8 accepted, ifid_pc4=12.
- Redirect with imem_ready=1 at pc=16, redirect_pc=0x40 -> data dropped, IF/ID bubble, next imem_addr=0x40.
- Redirect at pc=20 with imem_ready=0 for 3 cycles, second redirect to 0x80 during wait -> imem_addr stays 20 until ready; response dropped; next imem_addr=0x80; no valid IF/ID in between.
- pc=32'hFFFFFFFC accepted -> pc wraps to 0, ifid_pc4=0; reset asserted during a DISCARD wait -> pc=RESET_PC, state FETCH, pending redirect lost.
- With FETCH_PERF_CNT_EN: 3 stall cycles plus 2 redirects -> stall_cycles=3, bubble_cycles counts every bubble load (e.g. 5 for 3 stall+flush cycles plus 2 redirects with zero-wait memory).
